// File: rtl/load_store_unit_if.sv
// Request/response handshake plus word-wide data-memory bus for the load/store unit.
interface load_store_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic                  mem_w_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Control unit and data memory together form the master side.
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_w_en, mem_addr, mem_wdata
  );

  // The load/store unit.
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_w_en, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, byte/halfword stores by read-modify-write,
// sign/zero-extended loads, misaligned/illegal requests answered with an error.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WRITE, S_RESP} state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;
  logic                  mem_w_en_q, mem_w_en_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic                  req_err;
  logic [7:0]            lane_byte;
  logic [15:0]           lane_half;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] merged;

  // Classify the incoming request as misaligned or illegal.
  always_comb begin
    req_err = 1'b0;
    case (bus.req_funct3)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = bus.req_addr[0];
      3'b010:  req_err = (bus.req_addr[1:0] != 2'b00);
      3'b100:  req_err = bus.req_we;
      3'b101:  req_err = bus.req_we | bus.req_addr[0];
      default: req_err = 1'b1;
    endcase
  end

  // Select the addressed lane of the read word and extend it.
  always_comb begin
    lane_byte = '0;
    case (addr_q[1:0])
      2'd0: lane_byte = bus.mem_rdata[7:0];
      2'd1: lane_byte = bus.mem_rdata[15:8];
      2'd2: lane_byte = bus.mem_rdata[23:16];
      2'd3: lane_byte = bus.mem_rdata[31:24];
      default: lane_byte = '0;
    endcase
    lane_half = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    load_ext  = bus.mem_rdata;
    case (funct3_q)
      3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_ext = {24'h000000, lane_byte};
      3'b101:  load_ext = {16'h0000, lane_half};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  // Merge byte/halfword store data into the word read back from memory.
  always_comb begin
    merged = bus.mem_rdata;
    if (funct3_q[0] == 1'b0) begin
      case (addr_q[1:0])
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        2'd3: merged[31:24] = wdata_q[7:0];
        default: merged = bus.mem_rdata;
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  // Next-state and next-output logic; all outputs are registered, so values that must be
  // visible during a state are set on the edge that enters it.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_w_en_d   = mem_w_en_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d         = bus.req_we;
          funct3_d     = bus.req_funct3;
          addr_d       = bus.req_addr;
          wdata_d      = bus.req_wdata;
          req_ready_d  = 1'b0;
          resp_rdata_d = '0;
          resp_err_d   = req_err;
          if (req_err) begin
            resp_valid_d = 1'b1;
            state_d      = S_RESP;
          end else begin
            mem_addr_d = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
            if (bus.req_we && (bus.req_funct3 == 3'b010)) begin
              mem_w_en_d  = 1'b1;
              mem_wdata_d = bus.req_wdata;
            end
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (!we_q) begin
          resp_rdata_d = load_ext;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else if (funct3_q == 3'b010) begin
          mem_w_en_d   = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else begin
          mem_wdata_d = merged;
          mem_w_en_d  = 1'b1;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_w_en_d   = 1'b0;
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      funct3_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_w_en_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_w_en_q   <= mem_w_en_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_w_en   = mem_w_en_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule
